mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port memory between the instruction-fetch requester and the data-memory requester of the 5-stage pipeline, so instruction and data storage can live in one unified array. It runs a fixed-latency, one-outstanding-transaction protocol to the memory. Data requests have priority, with a starvation guard for fetch. Requesters stall on the request/grant handshake until their response pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DAT_WIDTH, 32, data width of all ports
- MEM_LAT, 2, cycles from mem_req_o to valid mem_rdata_i (≥1)
- STARVE_MAX, 4, consecutive contested data grants before fetch wins (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  DAT_WIDTH  fetched instruction word
- dm_req_i  in  1  data request
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DAT_WIDTH  write data
- dm_gnt_o  out  1  data request accepted this cycle
- dm_rvalid_o  out  1  one-cycle pulse: read data valid or write done
- dm_rdata_o  out  DAT_WIDTH  load data
- mem_req_o  out  1  one-cycle issue strobe to memory
- mem_we_o  out  1  write enable, held for transaction
- mem_addr_o  out  ADDR_WIDTH  address, held for transaction
- mem_wdata_o  out  DAT_WIDTH  write data, held for transaction
- mem_rdata_i  in  DAT_WIDTH  memory read data
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant is combinational from requests.
  - Only one request: grant it.
  - Both requests: grant dm, unless starve_cnt == STARVE_MAX, then grant if.
  - On any grant: latch owner, addr, we (0 for fetch), and wdata into mem_* registers; go to ISSUE.
- ISSUE: mem_req_o = 1 for exactly one cycle; lat_cnt cleared to 1; go to WAIT.
- WAIT: lat_cnt increments each cycle. When lat_cnt == MEM_LAT, capture mem_rdata_i into the owner's rdata register (reads only); go to RESP.
  - With MEM_LAT = 1, ISSUE goes directly to the capture condition, so WAIT lasts 1 cycle.
- RESP: owner's rvalid_o = 1.
  - RESP behaves as IDLE for arbitration, so a new grant may occur in this cycle.
  - With no grant, go to IDLE.
- starve_cnt:
  - Increments on a dm grant while if_req_i = 1, saturating at STARVE_MAX.
  - Clears on any if grant.
- Writes never modify dm_rdata_o or if_rdata_o.
- rdata outputs hold their last captured value until the next capture.
- Requester rules:
  - req, addr, we, and wdata stay stable until gnt.
  - A request dropped before gnt is ignored.
  - The requester may re-request in its own rvalid cycle.
- Width rule: lat_cnt is $clog2(MEM_LAT+1) bits wide. mem_* outputs are pass-through registers with no address arithmetic.

## Timing
- Cycle numbering: grant = cycle 0.
  - mem_req_o in cycle 1.
  - mem_rdata_i sampled at the end of cycle MEM_LAT+1.
  - rvalid in cycle MEM_LAT+2.
- Next grant possible in cycle MEM_LAT+2, giving a throughput of one transaction per MEM_LAT+2 cycles.
- Grant in IDLE and RESP is zero-cycle (combinational). No grant in ISSUE or WAIT.
- Reset values:
  - State = IDLE.
  - All gnt, rvalid, mem_req_o, mem_we_o, and busy_o = 0.
  - All data and address outputs = 0.
  - starve_cnt = 0, lat_cnt = 0.
- Reset mid-transaction: next cycle is IDLE, and no rvalid is emitted for the abandoned transaction. A memory write already strobed is not undone.
- Simultaneous requests in the RESP cycle follow the same priority as IDLE.

## Test plan
- Fetch read, with MEM_LAT=2. Stimulus: if_req_i=1, if_addr_i=0x0000_0004, memory returns 0x0050_0093.
  - if_gnt_o in cycle 0.
  - mem_req_o with mem_addr_o=0x4 in cycle 1.
  - if_rvalid_o with if_rdata_o=0x0050_0093 in cycle 4.
  - busy_o low in cycle 5.
- Contention. Stimulus: if and dm requests both in cycle 0 (dm read at 0x100).
  - dm_gnt_o in cycle 0, dm_rvalid_o in cycle 4.
  - if_gnt_o in cycle 4, if_rvalid_o in cycle 8.
- Data write. Stimulus: dm_we_i=1, dm_addr_i=0x100, dm_wdata_i=0xDEAD_BEEF.
  - mem_we_o=1, mem_wdata_o=0xDEAD_BEEF in cycle 1.
  - dm_rvalid_o in cycle 4.
  - dm_rdata_o unchanged.
- Starvation guard, with STARVE_MAX=2. Stimulus: both requesters held high continuously.
  - Grant order: dm, dm, if, dm, dm, if.
  - Grants are spaced 4 cycles apart.
- Reset mid-operation. Stimulus: rst_n=0 in cycle 2 of a fetch.
  - Cycle 3: busy_o=0, and if_rvalid_o is never pulsed.
  - A new request gets gnt in the first cycle after rst_n=1.
- Edge parameter, with MEM_LAT=1. Stimulus: fetch read.
  - rvalid in cycle 3.
  - Back-to-back reads complete every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and data access.
// Data requests have priority. A starvation counter lets fetch win after STARVE_MAX contested data grants.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DAT_WIDTH  = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DAT_WIDTH-1:0]  if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DAT_WIDTH-1:0]  dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DAT_WIDTH-1:0]  dm_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DAT_WIDTH-1:0]  mem_wdata_o,
   input  logic [DAT_WIDTH-1:0]  mem_rdata_i,
   output logic                  busy_o
);

   localparam int LAT_W    = $clog2(MEM_LAT + 1);
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t               state, state_nxt;
   owner_t               owner;
   logic [LAT_W-1:0]     lat_cnt;
   logic [STARVE_W-1:0]  starve_cnt;
   logic                 grant_if, grant_dm, starved, capture;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      capture   = 1'b0;
      state_nxt = state;
      starved   = (starve_cnt == STARVE_W'(STARVE_MAX));
      case (state)
         IDLE, RESP: begin
            // Grants are suppressed while reset is held so the handshake stays quiet.
            if (rst_n) begin
               if (dm_req_i && !(if_req_i && starved)) grant_dm = 1'b1;
               else if (if_req_i)                      grant_if = 1'b1;
            end
            state_nxt = (grant_if || grant_dm) ? ISSUE : IDLE;
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (lat_cnt == LAT_W'(MEM_LAT)) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the data-path registers are reset too, because their outputs must read zero after reset.
         state       <= IDLE;
         owner       <= OWN_IF;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
      end else begin
         state <= state_nxt;
         if (grant_if || grant_dm) begin
            owner       <= grant_dm ? OWN_DM : OWN_IF;
            mem_we_o    <= grant_dm & dm_we_i;
            mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
            if (grant_if)                    starve_cnt <= '0;
            else if (if_req_i && !starved)   starve_cnt <= starve_cnt + STARVE_W'(1);
         end
         if (state == ISSUE)                lat_cnt <= LAT_W'(1);
         else if (state == WAIT && !capture) lat_cnt <= lat_cnt + LAT_W'(1);
         // Writes complete with a response pulse but leave both read-data registers untouched.
         if (capture && !mem_we_o) begin
            if (owner == OWN_DM) dm_rdata_o <= mem_rdata_i;
            else                 if_rdata_o <= mem_rdata_i;
         end
      end
   end

   assign if_gnt_o    = grant_if;
   assign dm_gnt_o    = grant_dm;
   assign mem_req_o   = (state == ISSUE);
   assign busy_o      = (state != IDLE);
   assign if_rvalid_o = (state == RESP) && (owner == OWN_IF);
   assign dm_rvalid_o = (state == RESP) && (owner == OWN_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table for fetch/write/contention, then starvation,
// mid-transaction reset and a MEM_LAT=1 back-to-back sequence.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT a: MEM_LAT=2, STARVE_MAX=2
   logic        a_if_req = 1'b0, a_dm_req = 1'b0, a_dm_we = 1'b0;
   logic [31:0] a_if_addr = '0, a_dm_addr = '0, a_dm_wdata = '0;
   logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_req, a_mem_we, a_busy;
   logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

   // DUT b: MEM_LAT=1, fetch only
   logic        b_if_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
   logic [31:0] b_if_addr = '0, b_dm_addr = '0, b_dm_wdata = '0;
   logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_req, b_mem_we, b_busy;
   logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MEM_LAT(2), .STARVE_MAX(2)) u_a (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
      .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
      .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_addr_i(a_dm_addr), .dm_wdata_i(a_dm_wdata),
      .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rvalid), .dm_rdata_o(a_dm_rdata),
      .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
      .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata), .busy_o(a_busy));

   mem_port_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .MEM_LAT(1), .STARVE_MAX(4)) u_b (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
      .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
      .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
      .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rvalid), .dm_rdata_o(b_dm_rdata),
      .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
      .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .busy_o(b_busy));

   // Memory model: data is only valid in the single cycle the latency contract allows.
   logic [31:0] mem [0:255];
   int          a_age = 0, b_age = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[1]  <= 32'h0050_0093;
         mem[2]  <= 32'h0000_0013;
         mem[3]  <= 32'h00A0_0113;
         mem[64] <= 32'h1111_2222;
      end else if (a_mem_req && a_mem_we) begin
         mem[a_mem_addr[9:2]] <= a_mem_wdata;
      end
      a_age <= a_mem_req ? 1 : ((a_age != 0) ? a_age + 1 : 0);
      b_age <= b_mem_req ? 1 : ((b_age != 0) ? b_age + 1 : 0);
   end

   assign a_mem_rdata = (a_age == 2) ? mem[a_mem_addr[9:2]] : 32'hBADD_0BAD;
   assign b_mem_rdata = (b_age == 1) ? mem[b_mem_addr[9:2]] : 32'hBADD_0BAD;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, ireq;
      logic [31:0] iaddr;
      logic        dreq, dwe;
      logic [31:0] daddr, dwd;
      logic [5:0]  ctl;      // {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy}
      logic [31:0] ird, drd;
      logic        cm, mwe;
      logic [31:0] maddr;
      logic        cw;
      logic [31:0] mwd;
   } vec_t;

   function automatic vec_t mk(input logic rst, ireq, input logic [31:0] iaddr,
                               input logic dreq, dwe, input logic [31:0] daddr, dwd,
                               input logic [5:0] ctl, input logic [31:0] ird, drd,
                               input logic cm, mwe, input logic [31:0] maddr,
                               input logic cw, input logic [31:0] mwd);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
      v.daddr = daddr; v.dwd = dwd; v.ctl = ctl; v.ird = ird; v.drd = drd;
      v.cm = cm; v.mwe = mwe; v.maddr = maddr; v.cw = cw; v.mwd = mwd;
      return v;
   endfunction

   localparam logic [31:0] I1 = 32'h0050_0093;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1);
   end

   initial begin
      vec_t         vecs[$];
      logic [1:0]   kinds[$];
      int           cycles[$];
      logic [1:0]   exp_kind [6];

      // fetch read, data write, contention (MEM_LAT=2)
      vecs.push_back(mk(0,0,0,0,0,0,0, 6'b000000, 0,0, 1,0,0, 1,0));
      vecs.push_back(mk(1,1,32'h4,0,0,0,0, 6'b100000, 0,0, 1,0,0, 1,0));
      vecs.push_back(mk(1,0,32'h4,0,0,0,0, 6'b000011, 0,0, 1,0,32'h4, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, 0,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, 0,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b001001, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000000, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,1,1,32'h100,DB, 6'b010000, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000011, I1,0, 1,1,32'h100, 1,DB));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000101, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000000, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,1,32'h8,1,0,32'h100,0, 6'b010000, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,1,32'h8,0,0,0,0, 6'b000011, I1,0, 1,0,32'h100, 0,0));
      vecs.push_back(mk(1,1,32'h8,0,0,0,0, 6'b000001, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,1,32'h8,0,0,0,0, 6'b000001, I1,0, 0,0,0, 0,0));
      vecs.push_back(mk(1,1,32'h8,0,0,0,0, 6'b100101, I1,DB, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000011, I1,DB, 1,0,32'h8, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, I1,DB, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000001, I1,DB, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b001001, 32'h13,DB, 0,0,0, 0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0, 6'b000000, 32'h13,DB, 0,0,0, 0,0));

      repeat (2) @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst_n = vecs[i].rst;  a_if_req = vecs[i].ireq;  a_if_addr = vecs[i].iaddr;
         a_dm_req = vecs[i].dreq;  a_dm_we = vecs[i].dwe;
         a_dm_addr = vecs[i].daddr;  a_dm_wdata = vecs[i].dwd;
         #1;
         check($sformatf("row%0d ctl", i),
               {26'd0, a_if_gnt, a_dm_gnt, a_if_rvalid, a_dm_rvalid, a_mem_req, a_busy},
               {26'd0, vecs[i].ctl});
         check($sformatf("row%0d if_rdata", i), a_if_rdata, vecs[i].ird);
         check($sformatf("row%0d dm_rdata", i), a_dm_rdata, vecs[i].drd);
         if (vecs[i].cm) begin
            check($sformatf("row%0d mem_addr", i), a_mem_addr, vecs[i].maddr);
            check($sformatf("row%0d mem_we", i), {31'd0, a_mem_we}, {31'd0, vecs[i].mwe});
         end
         if (vecs[i].cw) check($sformatf("row%0d mem_wdata", i), a_mem_wdata, vecs[i].mwd);
      end

      // Starvation guard: both requesters held high, STARVE_MAX=2.
      exp_kind = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         a_if_req = 1'b1; a_if_addr = 32'hC;
         a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h100;
         #1;
         if (a_if_gnt || a_dm_gnt) begin
            kinds.push_back({a_if_gnt, a_dm_gnt});
            cycles.push_back(c);
         end
      end
      check("starve grant count", kinds.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("starve kind%0d", i),
               {30'd0, (i < kinds.size()) ? kinds[i] : 2'b11}, {30'd0, exp_kind[i]});
         if (i > 0)
            check($sformatf("starve gap%0d", i),
                  (i < cycles.size()) ? cycles[i] - cycles[i-1] : -1, 4);
      end
      for (int c = 21; c <= 25; c++) begin
         @(negedge clk);
         a_if_req = 1'b0; a_dm_req = 1'b0;
         #1;
      end
      check("starve drain busy", {31'd0, a_busy}, 32'd0);

      // Reset in cycle 2 of a fetch.
      @(negedge clk); a_if_req = 1'b1; a_if_addr = 32'h4; #1;
      check("rst c0 if_gnt", {31'd0, a_if_gnt}, 32'd1);
      @(negedge clk); a_if_req = 1'b0; #1;
      check("rst c1 mem_req", {31'd0, a_mem_req}, 32'd1);
      @(negedge clk); rst_n = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1; a_if_req = 1'b1; a_if_addr = 32'h4; #1;
      check("rst c3 busy", {31'd0, a_busy}, 32'd0);
      check("rst c3 if_rvalid", {31'd0, a_if_rvalid}, 32'd0);
      check("rst c3 if_gnt", {31'd0, a_if_gnt}, 32'd1);
      check("rst c3 if_rdata", a_if_rdata, 32'd0);
      for (int c = 4; c <= 6; c++) begin
         @(negedge clk); a_if_req = 1'b0; #1;
         check($sformatf("rst c%0d if_rvalid", c), {31'd0, a_if_rvalid}, 32'd0);
      end
      @(negedge clk); #1;
      check("rst c7 if_rvalid", {31'd0, a_if_rvalid}, 32'd1);
      check("rst c7 if_rdata", a_if_rdata, I1);
      @(negedge clk); #1;
      check("rst c8 busy", {31'd0, a_busy}, 32'd0);

      // MEM_LAT=1: back-to-back fetches every 3 cycles.
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         b_if_req  = (c <= 6);
         b_if_addr = 32'h4 + 32'h4 * 32'((c + 2) / 3);
         #1;
         check($sformatf("lat1 c%0d gnt", c), {31'd0, b_if_gnt},
               {31'd0, (c % 3 == 0) && (c <= 6)});
         check($sformatf("lat1 c%0d mem_req", c), {31'd0, b_mem_req},
               {31'd0, (c % 3 == 1) && (c <= 7)});
         check($sformatf("lat1 c%0d rvalid", c), {31'd0, b_if_rvalid},
               {31'd0, (c % 3 == 0) && (c >= 3)});
         if (c == 3) check("lat1 c3 rdata", b_if_rdata, I1);
         if (c == 6) check("lat1 c6 rdata", b_if_rdata, 32'h0000_0013);
         if (c == 9) check("lat1 c9 rdata", b_if_rdata, 32'h00A0_0113);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
